adder_seq_ctrl: RTL
===================

# adder_seq_ctrl

Multi-cycle sequencer that computes a WIDTH-bit sum by driving one SLICE-bit ripple adder slice over WIDTH/SLICE consecutive cycles and holding the inter-slice carry in a register. It trades latency for area: one shared slice replaces a full-width ripple chain. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. The ALU uses it wherever a wide add can tolerate multi-cycle latency.

## Interface
Parameters:
- WIDTH, default 64: operand and result width; must be an integer multiple of SLICE.
- SLICE, default 16: width of the internal adder slice.

Ports:
- clk  input  1  single clock; all state is updated on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry into bit 0.
- op_sub  input  1  subtract select; this port exists only when ADDER_SEQ_SUB_EN is defined.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of bit WIDTH-1.

## Operation
- N = WIDTH/SLICE slices. Slice index counter idx has width ceil(log2(N)), minimum 1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture a, b and c_in (carry register ← c_in), set idx←0, go to RUN.
- RUN:
  - Each cycle, slice idx adds a[idx*SLICE +: SLICE] + b_eff[idx*SLICE +: SLICE] + carry.
  - The slice sum is written into sum[idx*SLICE +: SLICE]; the slice carry-out is written to the carry register.
  - idx increments each cycle. After slice N-1, go to DONE with c_out ← final carry.
- DONE:
  - out_valid=1. sum and c_out are held stable.
  - On out_ready, go to IDLE.
- in_ready=0 in RUN and DONE. in_valid is ignored in those states, and operands are not re-sampled.
- b_eff = b when not subtracting.
- Arithmetic is modulo 2^WIDTH; c_out is the true carry out of the full-width add.
- sum bits above the current idx hold their previous values during RUN. They are not observable, because out_valid=0.

## Timing
- Reset values (applied asynchronously, released synchronously to clk):
  - state=IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, carry=0, idx=0.
- Latency:
  - Accept edge is E. out_valid rises after edge E+N (4 cycles for the defaults).
  - The earliest next accept is the edge after the out handshake edge.
  - Throughput is one operation per N+2 cycles.
- Backpressure: while out_ready=0 in DONE, the block stalls indefinitely with sum and c_out stable.
- Reset during RUN or DONE: the operation is discarded and outputs take their reset values immediately. No partial result is ever presented.
- Simultaneous events: in DONE, out_ready=1 together with in_valid=1 does not accept the new operands that cycle, because in_ready=0.
- N=1: RUN lasts one cycle.

## Configuration
- Macro: ADDER_SEQ_SUB_EN.
- Defined:
  - op_sub port is present and captured with the operands.
  - When op_sub=1: b_eff = ~b, the initial carry is forced to 1, c_in is ignored, and c_out=1 means no borrow.
  - When op_sub=0: behaviour is identical to add.
- Not defined:
  - No op_sub port; add only.
  - Subtract logic is absent from the RTL.

## Test plan
- Full-width carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=1, c_in=0 → sum=0, c_out=1; out_valid rises exactly 4 cycles after the accept edge.
- Cross-slice carry with c_in: a=0x0000_0001_0000_FFFF, b=0x1, c_in=1 → sum=0x0000_0001_0001_0001, c_out=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle in_valid with new operands → sum and c_out are unchanged, in_ready=0, and the new operands are not captured.
- Subtract (ADDER_SEQ_SUB_EN defined): a=5, b=7, op_sub=1, c_in=0 → sum=0xFFFF_FFFF_FFFF_FFFE, c_out=0. Then a=7, b=5 → sum=2, c_out=1.
- Reset mid-operation: assert rst two cycles after accept → out_valid=0, in_ready=1, sum=0 asynchronously. After release, a=3, b=4 → sum=7.
- Back-to-back: two transactions with out_ready tied high → second accept one cycle after the first out handshake; both results are correct, with 6-cycle spacing.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// Multi-cycle adder: one SLICE-bit slice is reused over WIDTH/SLICE cycles, and the carry is held between slices.
// Optional subtract support is enabled by defining ADDER_SEQ_SUB_EN.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// RUN   | one slice is added per cycle; idx selects the slice
// DONE  | out_valid=1; sum and c_out are held until out_ready
module adder_seq_ctrl #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef ADDER_SEQ_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_eff;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [SLICE:0]   slice_res;
  logic             carry_init;

`ifdef ADDER_SEQ_SUB_EN
  logic op_sub_q;

  // Subtraction is a + ~b + 1, so the first carry is forced to 1 and c_in is ignored.
  always_comb begin
    b_eff      = op_sub_q ? ~b_q : b_q;
    carry_init = op_sub ? 1'b1 : c_in;
  end
`else
  always_comb begin
    b_eff      = b_q;
    carry_init = c_in;
  end
`endif

  always_comb begin
    slice_res = {1'b0, a_q[idx*SLICE +: SLICE]}
              + {1'b0, b_eff[idx*SLICE +: SLICE]}
              + {{SLICE{1'b0}}, carry};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
`ifdef ADDER_SEQ_SUB_EN
      op_sub_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= carry_init;
            idx   <= '0;
            state <= RUN;
`ifdef ADDER_SEQ_SUB_EN
            op_sub_q <= op_sub;
`endif
          end
        end
        RUN: begin
          sum[idx*SLICE +: SLICE] <= slice_res[SLICE-1:0];
          carry                   <= slice_res[SLICE];
          if (idx == LAST) begin
            c_out <= slice_res[SLICE];
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
